// File: rtl/ped_crossing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ped_crossing_ctrl
// Description : Pedestrian signal stage; debounces the push-button and grants
//               WALK + flashing DONT_WALK at the start of a vehicle RED phase.
// Revision    : 1.0 - initial release
// ============================================================================
module ped_crossing_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WALK_SECS       = 10,
  parameter int FLASH_SECS      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       one_sec_tick,
  input  logic       red_light,
  input  logic       yellow_light,
  input  logic       green_light,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic       request_pending,
  output logic [5:0] walk_sec_left,
  output logic       abort_pulse
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_RED = 2'd1,
    S_WALK     = 2'd2,
    S_FLASH    = 2'd3
  } state_t;

  localparam logic [7:0] c_DB_MAX = 8'(DEBOUNCE_CYCLES);
  localparam logic [5:0] c_TOTAL  = 6'(WALK_SECS + FLASH_SECS);
  localparam logic [5:0] c_FLASH  = 6'(FLASH_SECS);

  logic       r_sync1;
  logic       r_sync2;
  logic [7:0] r_db_cnt;
  logic       r_red_prev;
  state_t     r_state;
  logic       r_walk;
  logic       r_dont_walk;
  logic       r_req;
  logic [5:0] r_secs;
  logic       r_abort;

  logic       w_press;
  logic       w_valid;
  logic       w_red_rise;
  logic       w_unsafe;
  logic [5:0] w_secs_dec;

  // Event fires on the edge where the count reaches DEBOUNCE_CYCLES, then the
  // counter saturates so a long hold produces only one event.
  assign w_press    = r_sync2 && (r_db_cnt == c_DB_MAX - 8'd1);
  assign w_valid    = (red_light ^ yellow_light ^ green_light)
                      & ~(red_light & yellow_light & green_light);
  assign w_red_rise = red_light & ~r_red_prev & w_valid;
  assign w_unsafe   = ~red_light | ~w_valid;
  assign w_secs_dec = (r_secs == 6'd0) ? 6'd0 : r_secs - 6'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_cnt   <= 8'd0;
      r_red_prev <= 1'b1;
    end else begin
      r_sync1    <= ped_btn;
      r_sync2    <= r_sync1;
      r_red_prev <= red_light;
      if (!r_sync2) begin
        r_db_cnt <= 8'd0;
      end else if (r_db_cnt != c_DB_MAX) begin
        r_db_cnt <= r_db_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_walk      <= 1'b0;
      r_dont_walk <= 1'b1;
      r_req       <= 1'b0;
      r_secs      <= 6'd0;
      r_abort     <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      if (w_press && (r_state == S_IDLE || r_state == S_WAIT_RED)) begin
        r_req <= 1'b1;
      end

      if (!en) begin
        r_state     <= S_IDLE;
        r_walk      <= 1'b0;
        r_dont_walk <= 1'b1;
        r_secs      <= 6'd0;
      end else if ((r_state == S_WALK || r_state == S_FLASH) && w_unsafe) begin
        r_state     <= S_IDLE;
        r_walk      <= 1'b0;
        r_dont_walk <= 1'b1;
        r_secs      <= 6'd0;
        r_abort     <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_req) begin
              r_state <= S_WAIT_RED;
            end
          end
          S_WAIT_RED: begin
            // Clearing here also absorbs a press landing in the same cycle.
            if (w_red_rise) begin
              r_state     <= S_WALK;
              r_walk      <= 1'b1;
              r_dont_walk <= 1'b0;
              r_secs      <= c_TOTAL;
              r_req       <= 1'b0;
            end
          end
          S_WALK: begin
            if (one_sec_tick) begin
              r_secs <= w_secs_dec;
              if (w_secs_dec == c_FLASH) begin
                r_state     <= S_FLASH;
                r_walk      <= 1'b0;
                r_dont_walk <= 1'b1;
              end
            end
          end
          S_FLASH: begin
            if (one_sec_tick) begin
              r_secs <= w_secs_dec;
              if (w_secs_dec == 6'd0) begin
                r_state     <= S_IDLE;
                r_dont_walk <= 1'b1;
              end else begin
                r_dont_walk <= ~r_dont_walk;
              end
            end
          end
        endcase
      end
    end
  end

  assign walk            = r_walk;
  assign dont_walk       = r_dont_walk;
  assign request_pending = r_req;
  assign walk_sec_left   = r_secs;
  assign abort_pulse     = r_abort;

endmodule
`default_nettype wire
